// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter.
// Two requesters (A: ALU results, B: load data) share the single register-file
// write port through valid/ready handshakes with round-robin priority. A busy
// scoreboard tracks registers with an outstanding producer and drives a
// decode-stage read-hazard stall.
//
// Ports:
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   a_valid/a_ready       requester A handshake; a_reg/a_data destination/data
//   b_valid/b_ready       requester B handshake; b_reg/b_data destination/data
//   issue_valid/issue_reg instruction issued with destination issue_reg
//   rs, rt, stall         decode sources and combinational hazard stall
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   busy                  scoreboard, one bit per register (bit 0 always 0)
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [ADDR_W-1:0]      a_reg,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [ADDR_W-1:0]      b_reg,
  input  logic [DATA_W-1:0]      b_data,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_reg,
  input  logic [ADDR_W-1:0]      rs,
  input  logic [ADDR_W-1:0]      rt,
  output logic                   stall,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic [(2**ADDR_W)-1:0] busy
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  // Priority pointer: 0 favours A, 1 favours B.
  logic              r_prio_b;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic [NREG-1:0]   r_busy;

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_hs_a;
  logic              w_hs_b;
  logic              w_hs;
  logic [ADDR_W-1:0] w_dest;
  logic [DATA_W-1:0] w_data;
  logic [NREG-1:0]   w_busy_nxt;

  // Round-robin grant; ready is independent of the scoreboard.
  assign w_grant_a = a_valid && (!b_valid || !r_prio_b);
  assign w_grant_b = b_valid && (!a_valid ||  r_prio_b);

  // Readies are held low while reset is asserted.
  assign a_ready = rst_n && w_grant_a;
  assign b_ready = rst_n && w_grant_b;

  assign w_hs_a = a_valid && a_ready;
  assign w_hs_b = b_valid && b_ready;
  assign w_hs   = w_hs_a || w_hs_b;
  assign w_dest = w_hs_b ? b_reg  : a_reg;
  assign w_data = w_hs_b ? b_data : a_data;

  // Scoreboard next state: an issue to the same register beats a completing write.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (issue_valid && (issue_reg == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if (w_hs && (w_dest == ADDR_W'(i))) begin
        w_busy_nxt[i] = 1'b0;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Pointer, write-port and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio_b   <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_busy     <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_rf_we <= 1'b0;
      if (w_hs) begin
        r_prio_b   <= w_hs_a;
        // Register 0 is hard-wired: the handshake completes but nothing is written.
        r_rf_we    <= (w_dest != '0);
        r_rf_waddr <= w_dest;
        r_rf_wdata <= w_data;
      end
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign busy     = r_busy;

  assign stall = ((rs != '0) && r_busy[rs]) || ((rt != '0) && r_busy[rt]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table applied one cycle per
// row, followed by hand-written reset and readback sequences.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic          clk;
  logic          rst_n;
  logic          a_valid, b_valid, issue_valid;
  logic          a_ready, b_ready, stall, rf_we;
  logic [AW-1:0] a_reg, b_reg, issue_reg, rs, rt, rf_waddr;
  logic [DW-1:0] a_data, b_data, rf_wdata;
  logic [NR-1:0] busy;

  int checks;
  int errors;

  logic [DW-1:0] model_rf [NR];

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .rs(rs), .rt(rt), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model driven by the DUT write port, committing on the falling edge.
  initial begin
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
  end
  always @(negedge clk) begin
    if (rf_we && (rf_waddr != '0)) model_rf[rf_waddr] <= rf_wdata;
  end

  typedef struct {
    logic          av;
    logic [AW-1:0] ar;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] br;
    logic [DW-1:0] bd;
    logic          iv;
    logic [AW-1:0] ir;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          e_ar;
    logic          e_br;
    logic          e_st;
    logic          e_we;
    logic          chk_rf;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    logic [NR-1:0] e_busy;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t mk(
    input logic av, input int ar, input logic [DW-1:0] ad,
    input logic bv, input int br, input logic [DW-1:0] bd,
    input logic iv, input int ir, input int vrs, input int vrt,
    input logic e_ar, input logic e_br, input logic e_st, input logic e_we,
    input logic chk_rf, input int e_wa, input logic [DW-1:0] e_wd,
    input logic [NR-1:0] e_busy);
    vec_t v;
    v.av = av; v.ar = AW'(ar); v.ad = ad;
    v.bv = bv; v.br = AW'(br); v.bd = bd;
    v.iv = iv; v.ir = AW'(ir); v.rs = AW'(vrs); v.rt = AW'(vrt);
    v.e_ar = e_ar; v.e_br = e_br; v.e_st = e_st; v.e_we = e_we;
    v.chk_rf = chk_rf; v.e_wa = AW'(e_wa); v.e_wd = e_wd; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic drive_idle();
    a_valid = 1'b0; a_reg = '0; a_data = '0;
    b_valid = 1'b0; b_reg = '0; b_data = '0;
    issue_valid = 1'b0; issue_reg = '0; rs = '0; rt = '0;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive_idle();
    rst_n = 1'b0;

    //          av ar  ad            bv br bd           iv ir rs rt | ar br st we chk wa wd            busy
    vecs[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 32'h0,        32'h0);
    vecs[1]  = mk(1, 8, 32'h12345678, 0, 0, 32'h0,       0, 0, 0, 0,  1, 0, 0, 0, 1, 0, 32'h0,        32'h0);
    vecs[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0,  0, 0, 0, 1, 1, 8, 32'h12345678, 32'h0);
    vecs[3]  = mk(0, 0, 32'h0,        1, 6, 32'hB6,      0, 0, 0, 0,  0, 1, 0, 0, 1, 8, 32'h12345678, 32'h0);
    vecs[4]  = mk(1, 3, 32'hA3,       1, 4, 32'hB4,      0, 0, 0, 0,  1, 0, 0, 1, 1, 6, 32'hB6,       32'h0);
    vecs[5]  = mk(1, 3, 32'hA3,       1, 4, 32'hB4,      0, 0, 0, 0,  0, 1, 0, 1, 1, 3, 32'hA3,       32'h0);
    vecs[6]  = mk(1, 3, 32'hA3,       1, 4, 32'hB4,      0, 0, 0, 0,  1, 0, 0, 1, 1, 4, 32'hB4,       32'h0);
    vecs[7]  = mk(1, 3, 32'hA3,       1, 4, 32'hB4,      0, 0, 0, 0,  0, 1, 0, 1, 1, 3, 32'hA3,       32'h0);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0,  0, 0, 0, 1, 1, 4, 32'hB4,       32'h0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0,  0, 0, 0, 0, 1, 4, 32'hB4,       32'h0);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0,  0, 0, 0, 0, 1, 4, 32'hB4,       32'h0);
    vecs[11] = mk(1, 10, 32'h10,      1, 11, 32'h11,     0, 0, 0, 0,  1, 0, 0, 0, 1, 4, 32'hB4,       32'h0);
    vecs[12] = mk(0, 0, 32'h0,        1, 11, 32'h11,     0, 0, 0, 0,  0, 1, 0, 1, 1, 10, 32'h10,      32'h0);
    vecs[13] = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0,  0, 0, 0, 1, 1, 11, 32'h11,      32'h0);
    vecs[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,       1, 9, 9, 0,  0, 0, 0, 0, 1, 11, 32'h11,      32'h0);
    vecs[15] = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 9, 0,  0, 0, 1, 0, 1, 11, 32'h11,      32'h200);
    vecs[16] = mk(0, 0, 32'h0,        1, 9, 32'h99,      0, 0, 9, 0,  0, 1, 1, 0, 1, 11, 32'h11,      32'h200);
    vecs[17] = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 9, 0,  0, 0, 0, 1, 1, 9, 32'h99,       32'h0);
    vecs[18] = mk(1, 9, 32'h77,       0, 0, 32'h0,       1, 9, 0, 9,  1, 0, 0, 0, 1, 9, 32'h99,       32'h0);
    vecs[19] = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 9,  0, 0, 1, 1, 1, 9, 32'h77,       32'h200);
    vecs[20] = mk(0, 0, 32'h0,        1, 9, 32'h98,      0, 0, 9, 0,  0, 1, 1, 0, 1, 9, 32'h77,       32'h200);
    vecs[21] = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 9, 0,  0, 0, 0, 1, 1, 9, 32'h98,       32'h0);
    vecs[22] = mk(1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,       1, 0, 0, 0,  1, 0, 0, 0, 1, 9, 32'h98,       32'h0);
    vecs[23] = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
    vecs[24] = mk(0, 0, 32'h0,        0, 0, 32'h0,       1, 5, 0, 0,  0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
    vecs[25] = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 5,  0, 0, 1, 0, 0, 0, 32'h0,        32'h20);
    vecs[26] = mk(1, 5, 32'h55,       0, 0, 32'h0,       0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 32'h0,        32'h20);
    vecs[27] = mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 0,  0, 0, 0, 1, 1, 5, 32'h55,       32'h0);

    // Outputs while reset is held from time zero.
    #3;
    check_bit("reset_rf_we", rf_we, 1'b0);
    check_word("reset_busy", busy, '0);
    check_word("reset_waddr_wdata", {27'h0, rf_waddr} | rf_wdata, '0);
    #9 rst_n = 1'b1;

    // Table: drive 1 ns after a rising edge, sample 4 ns later (before the falling edge).
    for (int k = 0; k < 28; k++) begin
      @(posedge clk);
      #1;
      a_valid = vecs[k].av; a_reg = vecs[k].ar; a_data = vecs[k].ad;
      b_valid = vecs[k].bv; b_reg = vecs[k].br; b_data = vecs[k].bd;
      issue_valid = vecs[k].iv; issue_reg = vecs[k].ir;
      rs = vecs[k].rs; rt = vecs[k].rt;
      #3;
      checks++;
      if ((a_ready !== vecs[k].e_ar) || (b_ready !== vecs[k].e_br) ||
          (stall !== vecs[k].e_st) || (rf_we !== vecs[k].e_we) ||
          (busy !== vecs[k].e_busy) ||
          (vecs[k].chk_rf && ((rf_waddr !== vecs[k].e_wa) || (rf_wdata !== vecs[k].e_wd)))) begin
        errors++;
        $display("FAIL vec%0d: got ar=%b br=%b st=%b we=%b wa=%0d wd=0x%08h busy=0x%08h required ar=%b br=%b st=%b we=%b wa=%0d wd=0x%08h busy=0x%08h (addr/data checked=%b)",
                 k, a_ready, b_ready, stall, rf_we, rf_waddr, rf_wdata, busy,
                 vecs[k].e_ar, vecs[k].e_br, vecs[k].e_st, vecs[k].e_we,
                 vecs[k].e_wa, vecs[k].e_wd, vecs[k].e_busy, vecs[k].chk_rf);
      end
    end

    // Register-0 write and issue leave no trace.
    check_bit("r0_busy0", busy[0], 1'b0);

    // Reset mid-traffic: A write to R12 registered, then reset before it commits.
    @(posedge clk);
    #1;
    drive_idle();
    a_valid = 1'b1; a_reg = AW'(12); a_data = 32'h0000C0DE;
    issue_valid = 1'b1; issue_reg = AW'(7);
    #3 check_bit("pre_reset_a_ready", a_ready, 1'b1);
    @(posedge clk);
    #1;
    check_bit("pre_reset_rf_we", rf_we, 1'b1);
    check_word("pre_reset_busy", busy, 32'h80);
    #1 rst_n = 1'b0;
    #1;
    check_bit("midreset_a_ready", a_ready, 1'b0);
    check_bit("midreset_rf_we", rf_we, 1'b0);
    check_word("midreset_busy", busy, '0);
    check_word("midreset_wdata", rf_wdata, '0);
    check_word("midreset_waddr", {27'h0, rf_waddr}, '0);
    @(negedge clk);
    #1;
    drive_idle();
    rst_n = 1'b1;

    // Pointer restored to A (it favoured B before reset).
    @(posedge clk);
    #1;
    a_valid = 1'b1; a_reg = AW'(3); a_data = 32'h1;
    b_valid = 1'b1; b_reg = AW'(4); b_data = 32'h2;
    #3;
    check_bit("post_reset_a_ready", a_ready, 1'b1);
    check_bit("post_reset_b_ready", b_ready, 1'b0);
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    #1;

    // Register-file readback through the falling-edge model.
    check_word("readback_r8", model_rf[8], 32'h12345678);
    check_word("readback_r9", model_rf[9], 32'h00000098);
    check_word("readback_r5", model_rf[5], 32'h00000055);
    check_word("readback_r3", model_rf[3], 32'h00000001);
    check_word("readback_r12_discarded", model_rf[12], 32'h0);
    check_word("readback_r0", model_rf[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
